// File: rtl/ir_ac_pkg.sv
// ---------------------------------------------------------------------------
// ir_ac_pkg
// Shared definitions for the IR air-conditioner remote: the scheduler that
// builds frames and the 38 kHz transmitter that shifts them out both import
// this package so the frame layout is defined in exactly one place.
//
// Contents:
//   - AC mode encodings and requester (key) index map
//   - default setpoint limits and frame header constants
//   - frame field offsets and packed frame layouts
//   - scheduler FSM state type
//   - frame checksum helper
// ---------------------------------------------------------------------------
package ir_ac_pkg;

    // Air-conditioner operating modes as carried in the frame.
    localparam logic [2:0] MODE_AUTO = 3'd0;
    localparam logic [2:0] MODE_COOL = 3'd1;
    localparam logic [2:0] MODE_DRY  = 3'd2;
    localparam logic [2:0] MODE_FAN  = 3'd3;
    localparam logic [2:0] MODE_HEAT = 3'd4;

    // Fixed key-to-requester map.
    localparam int REQ_POWER   = 0;
    localparam int REQ_TEMP_UP = 1;
    localparam int REQ_TEMP_DN = 2;
    localparam int REQ_MODE    = 3;

    // Default setpoint range in degC.
    localparam int AC_TEMP_MIN = 16;
    localparam int AC_TEMP_MAX = 30;
    localparam int AC_TEMP_RST = 26;

    // Constant parts of the two frame segments.
    localparam logic [26:0] AC_HDR35 = 27'h4010040;
    localparam logic [28:0] AC_HDR32 = 29'h0080100;

    // Field offsets inside tx_data35 / tx_data32.
    localparam int D35_HDR_LSB   = 0;
    localparam int D35_TEMP_LSB  = 27;
    localparam int D35_POWER_BIT = 31;
    localparam int D35_MODE_LSB  = 32;
    localparam int D32_CHK_LSB   = 0;
    localparam int D32_HDR_LSB   = 4;

    // First segment: state fields on top, constant header below.
    typedef struct packed {
        logic [2:0]  mode;
        logic        power;
        logic [3:0]  temp_code;
        logic [26:0] hdr;
    } frame35_t;

    // Second segment: constant header on top, 4-bit checksum below.
    typedef struct packed {
        logic [28:0] hdr;
        logic [3:0]  chk;
    } frame32_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_UPDATE,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP
    } sched_state_e;

    // Checksum is the 4-bit wrap-around sum of the three state fields.
    function automatic logic [3:0] frame_chk(input logic [2:0] mode,
                                             input logic       power,
                                             input logic [3:0] temp_code);
        return {1'b0, mode} + {3'b000, power} + temp_code;
    endfunction

endpackage

// File: rtl/ir_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ir_rr_arbiter
// Purely combinational round-robin arbiter. Grants the first set bit of
// `pending` found when scanning upward from index `ptr`, wrapping at N_REQ.
//
// Ports:
//   pending  in   N_REQ   latched requests
//   ptr      in   PTR_W   index with highest priority this round
//   grant    out  N_REQ   one-hot grant (all zero when nothing pending)
//   valid    out  1       at least one request pending
// ---------------------------------------------------------------------------
module ir_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] pending,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic             valid
);

    always_comb begin
        int idx;
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment, otherwise synthesis infers a latch.
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!valid && pending[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ir_ac_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// ir_ac_cmd_scheduler
// Holds the air-conditioner state (power, mode, setpoint), latches one-cycle
// key requests, serves them round-robin, applies each command and hands an
// encoded frame to the IR transmitter over a start/busy handshake. After
// every frame a minimum idle gap is enforced before the next one.
//
// Ports:
//   clk          in   1       system clock
//   rst          in   1       synchronous active-high reset
//   req          in   N_REQ   one-cycle key pulses (0 power, 1 up, 2 down, 3 mode)
//   tx_busy      in   1       transmitter is sending a frame
//   tx_start     out  1       one-cycle start pulse, tx_data* valid from here
//   tx_data35    out  35      first frame segment, held until next start
//   tx_data32    out  33      second frame segment, held until next start
//   sched_busy   out  1       FSM is not idle
//   err_timeout  out  1       sticky handshake-timeout flag
//   ac_power     out  1       current power state
//   ac_temp      out  5       current setpoint, degC
//   ac_mode      out  3       current mode (0 auto .. 4 heat)
// ---------------------------------------------------------------------------
module ir_ac_cmd_scheduler
    import ir_ac_pkg::*;
#(
    parameter int          N_REQ    = 4,
    parameter int          GAP_CYC  = 5_000_000,
    parameter int          ACK_TO   = 1024,
    parameter int          TEMP_MIN = AC_TEMP_MIN,
    parameter int          TEMP_MAX = AC_TEMP_MAX,
    parameter int          TEMP_RST = AC_TEMP_RST,
    parameter logic [26:0] HDR35    = AC_HDR35,
    parameter logic [28:0] HDR32    = AC_HDR32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             tx_busy,
    output logic             tx_start,
    output logic [34:0]      tx_data35,
    output logic [32:0]      tx_data32,
    output logic             sched_busy,
    output logic             err_timeout,
    output logic             ac_power,
    output logic [4:0]       ac_temp,
    output logic [2:0]       ac_mode
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int ACK_W = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;
    localparam int CNT_W = (GAP_W > ACK_W) ? GAP_W : ACK_W;

    // GAP lasts GAP_CYC cycles. WAIT_BUSY is entered one cycle after the
    // tx_start cycle, so its last count is ACK_TO-2 to time out exactly
    // ACK_TO cycles after tx_start rose.
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TO - 2);

    localparam logic [4:0] T_MIN = 5'(TEMP_MIN);
    localparam logic [4:0] T_MAX = 5'(TEMP_MAX);
    localparam logic [4:0] T_RST = 5'(TEMP_RST);

    sched_state_e     state;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] grant_q;
    logic [PTR_W-1:0] rr_ptr;
    logic [CNT_W-1:0] cnt;

    logic [N_REQ-1:0] arb_grant;
    logic             arb_valid;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] ptr_next;
    logic [N_REQ-1:0] pending_clr;

    logic             nx_power;
    logic [4:0]       nx_temp;
    logic [2:0]       nx_mode;
    logic             cmd_drop;

    logic             f_power;
    logic [4:0]       f_temp;
    logic [2:0]       f_mode;
    logic [4:0]       f_off;
    frame35_t         f35;
    frame32_t         f32;

    ir_rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .pending (pending),
        .ptr     (rr_ptr),
        .grant   (arb_grant),
        .valid   (arb_valid)
    );

    // One-hot grant to index, and the pointer for the next round.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) begin
                grant_idx = PTR_W'(i);
            end
        end
        if (int'(grant_idx) == N_REQ - 1) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + 1'b1;
        end
    end

    // The granted bit is cleared in the grant cycle; a new pulse on the same
    // line in that cycle wins because the OR with req is applied last.
    assign pending_clr = (state == ST_ARB) ? arb_grant : '0;

    // Effect of the registered grant on the AC state. Only meaningful in
    // UPDATE; elsewhere grant_q is stale and these values are ignored.
    always_comb begin
        nx_power = ac_power;
        nx_temp  = ac_temp;
        nx_mode  = ac_mode;
        cmd_drop = 1'b0;
        if (grant_q[REQ_POWER]) begin
            nx_power = ~ac_power;
        end else if (!ac_power) begin
            cmd_drop = 1'b1;
        end else if (grant_q[REQ_TEMP_UP]) begin
            if (ac_temp < T_MAX) nx_temp = ac_temp + 5'd1;
        end else if (grant_q[REQ_TEMP_DN]) begin
            if (ac_temp > T_MIN) nx_temp = ac_temp - 5'd1;
        end else if (grant_q[REQ_MODE]) begin
            nx_mode = (ac_mode >= MODE_HEAT) ? MODE_AUTO : ac_mode + 3'd1;
        end
    end

    // The frame launched from UPDATE must already carry the new state, which
    // is only registered at that same edge; from START the state is settled.
    always_comb begin
        if (state == ST_UPDATE) begin
            f_power = nx_power;
            f_temp  = nx_temp;
            f_mode  = nx_mode;
        end else begin
            f_power = ac_power;
            f_temp  = ac_temp;
            f_mode  = ac_mode;
        end
        f_off = f_temp - T_MIN;
        f35   = '{mode: f_mode, power: f_power, temp_code: f_off[3:0], hdr: HDR35};
        f32   = '{hdr: HDR32, chk: frame_chk(f_mode, f_power, f_off[3:0])};
    end

    assign sched_busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pending     <= '0;
            grant_q     <= '0;
            rr_ptr      <= '0;
            cnt         <= '0;
            tx_start    <= 1'b0;
            tx_data35   <= '0;
            tx_data32   <= '0;
            err_timeout <= 1'b0;
            ac_power    <= 1'b0;
            ac_temp     <= T_RST;
            ac_mode     <= MODE_COOL;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            pending  <= (pending & ~pending_clr) | req;
            tx_start <= 1'b0;
            cnt      <= '0;

            case (state)
                ST_IDLE: begin
                    if (|pending) state <= ST_ARB;
                end

                ST_ARB: begin
                    if (arb_valid) begin
                        grant_q <= arb_grant;
                        rr_ptr  <= ptr_next;
                        state   <= ST_UPDATE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_UPDATE: begin
                    ac_power <= nx_power;
                    ac_temp  <= nx_temp;
                    ac_mode  <= nx_mode;
                    if (cmd_drop) begin
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_START;
                        // Launch straight away unless a frame from before a
                        // reset is still on air.
                        if (!tx_busy) begin
                            tx_start  <= 1'b1;
                            tx_data35 <= f35;
                            tx_data32 <= f32;
                        end
                    end
                end

                ST_START: begin
                    if (tx_start) begin
                        state <= ST_WAIT_BUSY;
                    end else if (!tx_busy) begin
                        tx_start  <= 1'b1;
                        tx_data35 <= f35;
                        tx_data32 <= f32;
                    end
                end

                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (cnt == ACK_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_WAIT_DONE: begin
                    if (!tx_busy) state <= ST_GAP;
                end

                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_ac_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ir_ac_cmd_scheduler
// Self-checking bench for ir_ac_cmd_scheduler. A behavioural AC model pushes
// the expected frame to a queue whenever a key pulse is driven; a monitor
// pops and compares on every tx_start. A simple transmitter model answers
// the handshake automatically unless the test drives tx_busy by hand.
// ---------------------------------------------------------------------------
module tb_ir_ac_cmd_scheduler;

    localparam int G  = 40;   // GAP_CYC used for the run
    localparam int A  = 64;   // ACK_TO used for the run
    localparam int BL = 10;   // transmitter busy length

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic        tx_auto   = 1'b1;
    logic        auto_busy = 1'b0;
    logic        man_busy  = 1'b0;
    logic        tx_busy;
    logic        tx_start;
    logic [34:0] tx_data35;
    logic [32:0] tx_data32;
    logic        sched_busy;
    logic        err_timeout;
    logic        ac_power;
    logic [4:0]  ac_temp;
    logic [2:0]  ac_mode;

    assign tx_busy = tx_auto ? auto_busy : man_busy;

    ir_ac_cmd_scheduler #(
        .N_REQ   (4),
        .GAP_CYC (G),
        .ACK_TO  (A)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data35   (tx_data35),
        .tx_data32   (tx_data32),
        .sched_busy  (sched_busy),
        .err_timeout (err_timeout),
        .ac_power    (ac_power),
        .ac_temp     (ac_temp),
        .ac_mode     (ac_mode)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [34:0] d35;
        logic [32:0] d32;
    } frame_t;

    frame_t     exp_q[$];
    logic       m_power;
    logic [4:0] m_temp;
    logic [2:0] m_mode;

    int start_cnt      = 0;
    int last_start_cyc = -1;
    int fall_cyc       = -1;
    int reset_cyc      = 0;
    bit exact_gap      = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    function automatic frame_t model_frame();
        logic [4:0] code;
        logic [3:0] chk;
        code = m_temp - 5'd16;
        chk  = {1'b0, m_mode} + {3'b000, m_power} + code[3:0];
        return {m_mode, m_power, code[3:0], 27'h4010040, 29'h0080100, chk};
    endfunction

    task automatic model_apply(input int i);
        if (i == 0) begin
            m_power = ~m_power;
        end else if (!m_power) begin
            return;
        end else if (i == 1) begin
            if (m_temp < 5'd30) m_temp = m_temp + 5'd1;
        end else if (i == 2) begin
            if (m_temp > 5'd16) m_temp = m_temp - 5'd1;
        end else begin
            m_mode = (m_mode == 3'd4) ? 3'd0 : m_mode + 3'd1;
        end
        exp_q.push_back(model_frame());
    endtask

    // Drive one key pulse; smp is the cycle index of the edge that samples it.
    task automatic pulse(input logic [3:0] mask, output int smp);
        @(posedge clk);
        #1;
        req = mask;
        smp = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) model_apply(i);
        end
        @(posedge clk);
        #1;
        req = '0;
    endtask

    task automatic wait_start(input int budget, output bit found);
        found = 1'b0;
        for (int k = 0; k < budget && !found; k++) begin
            @(negedge clk);
            if (tx_start) found = 1'b1;
        end
    endtask

    task automatic settle(input string tag, input int budget);
        int quiet = 0;
        for (int k = 0; k < budget && quiet < 3; k++) begin
            @(negedge clk);
            if (!sched_busy && !tx_busy) quiet++;
            else quiet = 0;
        end
        check({tag, "_idle"}, quiet >= 3, 1);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        reset_cyc = cyc;
        exp_q.delete();
        m_power = 1'b0;
        m_temp  = 5'd26;
        m_mode  = 3'd1;
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge clk);
        check({tag, "_tx_start"},  tx_start,    0);
        check({tag, "_data35"},    tx_data35,   0);
        check({tag, "_data32"},    tx_data32,   0);
        check({tag, "_sched"},     sched_busy,  0);
        check({tag, "_err"},       err_timeout, 0);
        check({tag, "_power"},     ac_power,    0);
        check({tag, "_temp"},      ac_temp,     26);
        check({tag, "_mode"},      ac_mode,     1);
    endtask

    // Scoreboard monitor: every start must match the oldest expected frame
    // and respect the inter-frame gap.
    initial begin
        frame_t f;
        forever begin
            @(negedge clk);
            if (!rst && tx_start) begin
                start_cnt++;
                check("frame_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    f = exp_q.pop_front();
                    check("data35", tx_data35, f.d35);
                    check("data32", tx_data32, f.d32);
                end
                if (fall_cyc > last_start_cyc && fall_cyc > reset_cyc) begin
                    check("gap_min", (cyc - fall_cyc) >= G, 1);
                    if (exact_gap) check("gap_exact", cyc - fall_cyc, G + 4);
                end
                last_start_cyc = cyc;
            end
        end
    end

    // Transmitter model: busy rises three cycles after start, lasts BL cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_auto && tx_start && !rst) begin
                repeat (3) @(posedge clk);
                #1;
                auto_busy = 1'b1;
                repeat (BL) @(posedge clk);
                #1;
                auto_busy = 1'b0;
                fall_cyc  = cyc;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int smp, s, e, n0;
        bit found;

        do_reset();
        check_reset_vals("rst0");

        // 1: power on, latency and literal frame fields.
        pulse(4'b0001, smp);
        wait_start(20, found);
        check("t1_start_seen", found, 1);
        check("t1_latency", cyc - smp, 3);
        check("t1_d35_fields", tx_data35[34:27], 8'b001_1_1010);
        check("t1_chk", tx_data32[3:0], 4'd12);
        settle("t1", 300);
        check("t1_power", ac_power, 1);

        // 2: power off, then a temp key is dropped without a frame.
        pulse(4'b0001, smp);
        settle("t2a", 300);
        check("t2_power", ac_power, 0);
        n0 = start_cnt;
        pulse(4'b0010, smp);
        settle("t2b", 50);
        repeat (10) @(negedge clk);
        check("t2_no_start", start_cnt, n0);
        check("t2_temp", ac_temp, 26);
        check("t2_sched_idle", sched_busy, 0);

        // 3: saturation at both ends, frames still sent.
        pulse(4'b0001, smp);
        settle("t3_on", 300);
        for (int i = 0; i < 5; i++) begin
            pulse(4'b0010, smp);
            settle("t3_up", 300);
            check("t3_temp_up", ac_temp, m_temp);
        end
        check("t3_temp_max", ac_temp, 30);
        for (int i = 0; i < 15; i++) begin
            pulse(4'b0100, smp);
            settle("t3_dn", 300);
            check("t3_temp_dn", ac_temp, m_temp);
        end
        check("t3_temp_min", ac_temp, 16);

        // 4: all four keys at once from rr_ptr=0, served 0,1,2,3.
        do_reset();
        exact_gap = 1'b1;
        n0 = start_cnt;
        pulse(4'b1111, smp);
        settle("t4", 1000);
        exact_gap = 1'b0;
        check("t4_frames", start_cnt - n0, 4);
        check("t4_power", ac_power, 1);
        check("t4_temp", ac_temp, 26);
        check("t4_mode", ac_mode, 2);

        // 5: transmitter never answers -> timeout exactly ACK_TO after start.
        tx_auto  = 1'b0;
        man_busy = 1'b0;
        pulse(4'b1000, smp);
        wait_start(20, found);
        check("t5_start_seen", found, 1);
        s = cyc;
        e = s;
        for (int k = 0; k < A + 20; k++) begin
            @(negedge clk);
            e = cyc;
            if (err_timeout) break;
        end
        check("t5_timeout_lat", e - s, A);
        check("t5_sched_idle", sched_busy, 0);
        repeat (5) @(negedge clk);
        check("t5_err_sticky", err_timeout, 1);
        check("t5_mode_applied", ac_mode, 3);

        // 6: reset during WAIT_DONE with the transmitter still busy.
        pulse(4'b0001, smp);
        wait_start(20, found);
        check("t6_start_seen", found, 1);
        @(posedge clk);
        #1;
        man_busy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t6_busy_before_rst", sched_busy, 1);
        check("t6_err_before_rst", err_timeout, 1);
        do_reset();
        check_reset_vals("t6_rst");
        n0 = start_cnt;
        pulse(4'b0001, smp);
        repeat (20) @(negedge clk);
        check("t6_held_off", start_cnt, n0);
        check("t6_waiting", sched_busy, 1);
        @(posedge clk);
        #1;
        man_busy = 1'b0;
        wait_start(10, found);
        check("t6_start_after_fall", found, 1);
        @(posedge clk);
        #1;
        man_busy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        man_busy = 1'b0;
        settle("t6", 300);
        check("t6_power", ac_power, 1);
        check("t6_err_clear", err_timeout, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
